// File: rtl/helix_thought_unpacker.sv
// helix_thought_unpacker: slices queued thought words into context beats by precision mode.
// Define HELIX_UNPACK_STATS_EN to add thought_count/beat_count ports.
module helix_thought_unpacker #(
    parameter int CONTEXT_W = 8,
    parameter int THOUGHT_W = 32,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 thought_valid,
    output logic                 thought_ready,
    input  logic [THOUGHT_W-1:0] thought_data,
    input  logic [1:0]           precision_mode,
    output logic                 ctx_valid,
    input  logic                 ctx_ready,
    output logic [CONTEXT_W-1:0] ctx_data,
    output logic                 ctx_last
`ifdef HELIX_UNPACK_STATS_EN
    ,
    output logic [15:0]          thought_count,
    output logic [15:0]          beat_count
`endif
);
    localparam int SLICES = THOUGHT_W / CONTEXT_W;
    localparam int SW = $clog2(SLICES);
    localparam int AW = $clog2(DEPTH);
    localparam logic [SW-1:0] TOP = SW'(SLICES - 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [THOUGHT_W+1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          occ;
    logic [SW-1:0]        cnt, idx, last_idx;
    logic [1:0]           mode;
    logic [THOUGHT_W-1:0] word;
    logic                 empty, push, load, pop;

    assign {mode, word}  = mem[rd_ptr];
    assign empty         = occ == '0;
    assign thought_ready = rst_n && occ != FULL;
    assign push          = thought_valid && thought_ready;
    assign load          = (!ctx_valid || ctx_ready) && !empty;
    assign pop           = load && cnt == last_idx;

    // beat counter maps to a slice index; mode 10 walks downward from the top slice
    always_comb begin
        idx      = mode == 2'b11 ? cnt : mode == 2'b10 ? TOP - cnt : mode == 2'b01 ? TOP : '0;
        last_idx = mode == 2'b11 ? TOP : mode == 2'b10 ? SW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {precision_mode, thought_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            cnt       <= '0;
            ctx_valid <= 1'b0;
            ctx_data  <= '0;
            ctx_last  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
            if (load) begin
                ctx_valid <= 1'b1;
                ctx_data  <= word[idx*CONTEXT_W +: CONTEXT_W];
                ctx_last  <= pop;
                cnt       <= pop ? '0 : cnt + 1'b1;
            end else if (ctx_ready) begin
                ctx_valid <= 1'b0;
            end
        end
    end

`ifdef HELIX_UNPACK_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            thought_count <= '0;
            beat_count    <= '0;
        end else begin
            thought_count <= thought_count + 16'(push);
            beat_count    <= beat_count + 16'(ctx_valid && ctx_ready);
        end
    end
`endif
endmodule
